fifo_flex: RTL and testbench

FIFO_FLEX -- requirements
Module: fifo_flex

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_flex_mem.sv | 23 ++
 rtl/fifo_flex.sv | 96 +++++++++
 tb/tb_fifo_flex.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and parameter-legality check for the flexible FIFO.
package fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Returns 1 when the FIFO parameter set is legal.
  function automatic bit params_ok(input int unsigned data_width,
                                   input int unsigned fifo_depth,
                                   input int unsigned addr_width,
                                   input int unsigned fwft,
                                   input int unsigned af_thresh,
                                   input int unsigned ae_thresh);
    bit ok;
    ok = 1'b1;
    if (data_width < 1) ok = 1'b0;
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) ok = 1'b0;
    if (addr_width != 32'($clog2(fifo_depth))) ok = 1'b0;
    if (fwft != FWFT_OFF && fwft != FWFT_ON) ok = 1'b0;
    if (af_thresh < 1 || af_thresh > fifo_depth) ok = 1'b0;
    if (ae_thresh > fifo_depth - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, never cleared.
module fifo_flex_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with selectable registered / first-word-fall-through read,
// threshold flags and sticky overflow/underflow.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (!params_ok(DATA_WIDTH, FIFO_DEPTH, ADDR_WIDTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("fifo_flex: illegal parameter set");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= PW'(AF_THRESH));
  assign almost_empty = (count <= PW'(AE_THRESH));

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !wr_acc) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  fifo_flex_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc & ~flush),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(din),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign dout = empty ? '0 : rdata;
  end else begin : g_reg
    // Read data lands one edge after the accepted pop and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout <= '0;
      else if (flush)  dout <= '0;
      else if (rd_acc) dout <= rdata;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench: depth-4 registered-read instance and depth-16 FWFT instance.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_flush, a_wr, a_rd;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [2:0] a_count;

  logic       b_flush, b_wr, b_rd;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] b_count;

  int n_pass = 0;
  int n_checks = 0;

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .din(a_din),
    .rd_en(a_rd), .dout(a_dout), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_d16 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .din(b_din),
    .rd_en(b_rd), .dout(b_dout), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_flush, a_wr, a_rd, a_din} = '0;
    {b_flush, b_wr, b_rd, b_din} = '0;
    #1;
    check("rst_a_empty", 32'(a_empty), 32'(1));
    check("rst_a_full",  32'(a_full),  32'(0));
    check("rst_a_count", 32'(a_count), 32'(0));
    check("rst_a_ae",    32'(a_ae),    32'(1));
    check("rst_a_af",    32'(a_af),    32'(0));
    check("rst_a_flags", 32'({a_ovf, a_unf}), 32'(0));
    check("rst_a_dout",  32'(a_dout),  32'(0));
    check("rst_b_dout",  32'(b_dout),  32'(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // Fill depth-4 FIFO, then overfill
    for (int i = 1; i <= 4; i++) begin
      a_wr = 1'b1; a_din = 8'(160 + i);
      step();
      check($sformatf("fill_cnt%0d", i), 32'(a_count), 32'(i));
      check($sformatf("fill_full%0d", i), 32'(a_full), 32'(i == 4));
      check($sformatf("fill_af%0d", i), 32'(a_af), 32'(i >= 2));
    end
    a_din = 8'hA5;
    step();
    a_wr = 1'b0;
    check("ovf_cnt",  32'(a_count), 32'(4));
    check("ovf_flag", 32'(a_ovf),   32'(1));
    check("ovf_full", 32'(a_full),  32'(1));

    a_rd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("rd_a%0d", i), 32'(a_dout), 32'(160 + i));
    end
    a_rd = 1'b0;
    check("drain_empty", 32'(a_empty), 32'(1));
    check("drain_unf",   32'(a_unf),   32'(0));

    // Read of empty FIFO
    a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    check("unf_flag", 32'(a_unf),  32'(1));
    check("unf_dout", 32'(a_dout), 32'(8'hA4));

    // Flush with a concurrent write
    a_flush = 1'b1; a_wr = 1'b1; a_din = 8'hEE;
    step();
    a_flush = 1'b0; a_wr = 1'b0;
    check("flush_cnt",   32'(a_count), 32'(0));
    check("flush_empty", 32'(a_empty), 32'(1));
    check("flush_flags", 32'({a_ovf, a_unf}), 32'(0));
    check("flush_dout",  32'(a_dout),  32'(0));
    a_wr = 1'b1; a_din = 8'h11;
    step();
    a_wr = 1'b0; a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    check("post_flush_rd", 32'(a_dout), 32'(8'h11));

    // Write+read while full
    for (int i = 1; i <= 4; i++) begin
      a_wr = 1'b1; a_din = 8'(176 + i);
      step();
    end
    a_rd = 1'b1; a_din = 8'hB5;
    step();
    a_wr = 1'b0;
    check("wrf_cnt",  32'(a_count), 32'(4));
    check("wrf_full", 32'(a_full),  32'(1));
    check("wrf_ovf",  32'(a_ovf),   32'(0));
    check("wrf_dout", 32'(a_dout),  32'(8'hB1));
    for (int i = 2; i <= 5; i++) begin
      step();
      check($sformatf("rd_b%0d", i), 32'(a_dout), 32'(176 + i));
    end
    a_rd = 1'b0;
    check("wrf_empty", 32'(a_empty), 32'(1));

    // FWFT single word
    check("fw_empty0", 32'(b_empty), 32'(1));
    check("fw_dout0",  32'(b_dout),  32'(0));
    b_wr = 1'b1; b_din = 8'hC1;
    step();
    b_wr = 1'b0;
    check("fw_empty1", 32'(b_empty), 32'(0));
    check("fw_dout1",  32'(b_dout),  32'(8'hC1));
    step();
    check("fw_hold", 32'(b_dout), 32'(8'hC1));
    b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    check("fw_pop_dout",  32'(b_dout),  32'(0));
    check("fw_pop_empty", 32'(b_empty), 32'(1));

    // Depth-16 thresholds
    for (int i = 0; i < 16; i++) begin
      b_wr = 1'b1; b_din = 8'(i);
      step();
      check($sformatf("b_cnt%0d", i + 1), 32'(b_count), 32'(i + 1));
      check($sformatf("b_ae%0d", i + 1), 32'(b_ae), 32'(i + 1 <= 2));
      check($sformatf("b_af%0d", i + 1), 32'(b_af), 32'(i + 1 >= 14));
      check($sformatf("b_full%0d", i + 1), 32'(b_full), 32'(i + 1 == 16));
    end
    b_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b_head%0d", i), 32'(b_dout), 32'(i));
      b_rd = 1'b1;
      step();
      b_rd = 1'b0;
      check($sformatf("b_dcnt%0d", i), 32'(b_count), 32'(15 - i));
      check($sformatf("b_dae%0d", i), 32'(b_ae), 32'(15 - i <= 2));
    end

    // Pointer wrap
    for (int k = 0; k < 40; k++) begin
      b_wr = 1'b1; b_din = 8'(k * 3 + 7);
      step();
      b_wr = 1'b0;
      check($sformatf("wrap_dout%0d", k), 32'(b_dout), 32'(8'(k * 3 + 7)));
      check($sformatf("wrap_cnt%0d", k), 32'(b_count), 32'(1));
      b_rd = 1'b1;
      step();
      b_rd = 1'b0;
      check($sformatf("wrap_empty%0d", k), 32'(b_empty), 32'(1));
    end
    check("b_flags", 32'({b_ovf, b_unf}), 32'(0));

    // Simultaneous read/write, not full
    b_wr = 1'b1; b_din = 8'h55;
    step();
    b_rd = 1'b1; b_din = 8'h66;
    step();
    b_wr = 1'b0; b_rd = 1'b0;
    check("sim_cnt",  32'(b_count), 32'(1));
    check("sim_dout", 32'(b_dout),  32'(8'h66));

    // Asynchronous reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      a_wr = 1'b1; a_din = 8'(48 + i);
      step();
    end
    a_wr = 1'b0;
    check("pre_rst_cnt", 32'(a_count), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt",   32'(a_count), 32'(0));
    check("arst_empty", 32'(a_empty), 32'(1));
    check("arst_full",  32'(a_full),  32'(0));
    check("arst_ae",    32'(a_ae),    32'(1));
    check("arst_dout",  32'(a_dout),  32'(0));
    check("arst_b_cnt", 32'(b_count), 32'(0));
    step();
    rst_n = 1'b1;
    a_wr = 1'b1; a_din = 8'hD1;
    step();
    a_wr = 1'b0; a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    check("post_rst_rd",  32'(a_dout),  32'(8'hD1));
    check("post_rst_cnt", 32'(a_count), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
